// File: rtl/pcap_stream_writer.sv
// pcap_stream_writer
//   Turns a framed input byte stream into a byte-serial libpcap file image:
//   a 24-byte global header once after reset, then for every packet a
//   16-byte record header followed by the captured payload. The whole
//   packet is buffered first, because its record header carries the length
//   ahead of the payload.
//
//   Build option: define PCAP_NSEC_EN for the nanosecond pcap variant
//   (magic a1b23c4d, ts_frac wraps at 999999999). Without it the file is
//   microsecond format (magic a1b2c3d4, ts_frac wraps at 999999).
//
// Ports
//   CLOCK      in   sole clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   datavalid  in   input byte valid
//   data       in   input byte [7:0]
//   eop        in   current input byte is the last of its packet
//   ready      out  input byte accepted when datavalid && ready
//   outvalid   out  outdata valid
//   outdata    out  pcap byte [7:0]
//   pause      in   output backpressure; transfer when outvalid && !pause
//   pktcount   out  records fully emitted [7:0], wraps
//   truncated  out  sticky, a packet exceeded the buffer capacity
//
// state   | meaning
// GHDR    | emitting the 24-byte global header
// CAPTURE | accepting packet bytes into the buffer
// RHDR    | emitting the 16-byte record header
// PAYLOAD | emitting buffered payload bytes

module pcap_stream_writer #(
   parameter int BUF_AW         = 11,
   parameter int SNAPLEN        = 65535,
   parameter int LINKTYPE       = 1,
   parameter int TICKS_PER_FRAC = 1
) (
   input  logic       CLOCK,
   input  logic       RESET_N,
   input  logic       datavalid,
   input  logic [7:0] data,
   input  logic       eop,
   output logic       ready,
   output logic       outvalid,
   output logic [7:0] outdata,
   input  logic       pause,
   output logic [7:0] pktcount,
   output logic       truncated
);

`ifdef PCAP_NSEC_EN
   localparam logic [31:0] MAGIC    = 32'ha1b2_3c4d;
   localparam logic [31:0] FRAC_MAX = 32'd999_999_999;
`else
   localparam logic [31:0] MAGIC    = 32'ha1b2_c3d4;
   localparam logic [31:0] FRAC_MAX = 32'd999_999;
`endif

   // byte 0 of the header sits in bits [7:0]
   localparam logic [191:0] GHDR_VEC = {32'(LINKTYPE), 32'(SNAPLEN),
                                        32'h0, 32'h0, 32'h0004_0002, MAGIC};
   localparam logic [31:0]  PRESC_LOAD = 32'(TICKS_PER_FRAC - 1);

   typedef enum logic [1:0] {
      S_GHDR    = 2'd0,
      S_CAPTURE = 2'd1,
      S_RHDR    = 2'd2,
      S_PAYLOAD = 2'd3
   } state_t;

   // reset asserts asynchronously, releases two clocks later in step with CLOCK
   logic [1:0] rst_sync;
   logic       rst_b;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_b = rst_sync[1];

   // free-running timestamp
   logic [31:0] presc;
   logic [31:0] ts_sec;
   logic [31:0] ts_frac;

   always_ff @(posedge CLOCK or negedge rst_b) begin
      if (!rst_b) begin
         presc   <= PRESC_LOAD;
         ts_sec  <= '0;
         ts_frac <= '0;
      end else if (presc == 32'd0) begin
         presc <= PRESC_LOAD;
         if (ts_frac == FRAC_MAX) begin
            ts_frac <= '0;
            ts_sec  <= ts_sec + 32'd1;
         end else begin
            ts_frac <= ts_frac + 32'd1;
         end
      end else begin
         presc <= presc - 32'd1;
      end
   end

   state_t          state, state_nxt;
   logic [4:0]      hdr_idx, hdr_idx_nxt;
   logic [BUF_AW:0] rd_ptr, rd_ptr_nxt;
   logic [BUF_AW:0] incl_len, incl_len_nxt;
   logic [31:0]     orig_len, orig_len_nxt;
   logic [31:0]     pkt_sec, pkt_sec_nxt;
   logic [31:0]     pkt_frac, pkt_frac_nxt;
   logic            ov, ov_nxt;
   logic [7:0]      od, od_nxt;
   logic [7:0]      pkt_cnt, pkt_cnt_nxt;
   logic            trunc, trunc_nxt;
   logic            wr_en;
   logic            adv;
   logic            accept;
   logic [7:0]      ghdr_byte;
   logic [7:0]      rhdr_byte;
   logic [127:0]    rhdr_vec;

   // packet buffer, synchronous read
   logic [7:0] mem [0:(1<<BUF_AW)-1];
   logic [7:0] mem_q;

   always_ff @(posedge CLOCK) begin
      if (wr_en) mem[incl_len[BUF_AW-1:0]] <= data;
      // reading at the next pointer keeps mem_q one byte ahead of outdata
      mem_q <= mem[rd_ptr_nxt[BUF_AW-1:0]];
   end

   assign adv       = !ov || !pause;
   assign accept    = datavalid && (state == S_CAPTURE);
   assign rhdr_vec  = {orig_len, 32'(incl_len), pkt_frac, pkt_sec};
   assign ghdr_byte = (hdr_idx < 5'd24) ? GHDR_VEC[{hdr_idx, 3'b000} +: 8] : 8'h00;
   assign rhdr_byte = rhdr_vec[{hdr_idx[3:0], 3'b000} +: 8];

   always_ff @(posedge CLOCK or negedge rst_b) begin
      if (!rst_b) begin
         state    <= S_GHDR;
         hdr_idx  <= '0;
         rd_ptr   <= '0;
         incl_len <= '0;
         orig_len <= '0;
         pkt_sec  <= '0;
         pkt_frac <= '0;
         ov       <= 1'b0;
         od       <= '0;
         pkt_cnt  <= '0;
         trunc    <= 1'b0;
      end else begin
         state    <= state_nxt;
         hdr_idx  <= hdr_idx_nxt;
         rd_ptr   <= rd_ptr_nxt;
         incl_len <= incl_len_nxt;
         orig_len <= orig_len_nxt;
         pkt_sec  <= pkt_sec_nxt;
         pkt_frac <= pkt_frac_nxt;
         ov       <= ov_nxt;
         od       <= od_nxt;
         pkt_cnt  <= pkt_cnt_nxt;
         trunc    <= trunc_nxt;
      end
   end

   // In the emitting states the state names the section of the next byte to
   // load into the output register, so a section boundary costs no cycle.
   always_comb begin
      state_nxt    = state;
      hdr_idx_nxt  = hdr_idx;
      rd_ptr_nxt   = rd_ptr;
      incl_len_nxt = incl_len;
      orig_len_nxt = orig_len;
      pkt_sec_nxt  = pkt_sec;
      pkt_frac_nxt = pkt_frac;
      ov_nxt       = ov;
      od_nxt       = od;
      pkt_cnt_nxt  = pkt_cnt;
      trunc_nxt    = trunc;
      wr_en        = 1'b0;
      case (state)
         S_GHDR: begin
            if (adv) begin
               if (hdr_idx == 5'd24) begin
                  ov_nxt      = 1'b0;
                  hdr_idx_nxt = '0;
                  state_nxt   = S_CAPTURE;
               end else begin
                  ov_nxt      = 1'b1;
                  od_nxt      = ghdr_byte;
                  hdr_idx_nxt = hdr_idx + 5'd1;
               end
            end
         end
         S_CAPTURE: begin
            if (accept) begin
               if (orig_len == 32'd0) begin
                  pkt_sec_nxt  = ts_sec;
                  pkt_frac_nxt = ts_frac;
               end
               orig_len_nxt = orig_len + 32'd1;
               if (!incl_len[BUF_AW]) begin
                  wr_en        = 1'b1;
                  incl_len_nxt = incl_len + 1'b1;
               end else begin
                  trunc_nxt = 1'b1;
               end
               if (eop) begin
                  hdr_idx_nxt = '0;
                  state_nxt   = S_RHDR;
               end
            end
         end
         S_RHDR: begin
            if (adv) begin
               ov_nxt = 1'b1;
               od_nxt = rhdr_byte;
               if (hdr_idx == 5'd15) begin
                  hdr_idx_nxt = '0;
                  state_nxt   = S_PAYLOAD;
               end else begin
                  hdr_idx_nxt = hdr_idx + 5'd1;
               end
            end
         end
         S_PAYLOAD: begin
            if (adv) begin
               if (rd_ptr == incl_len) begin
                  ov_nxt       = 1'b0;
                  pkt_cnt_nxt  = pkt_cnt + 8'd1;
                  rd_ptr_nxt   = '0;
                  incl_len_nxt = '0;
                  orig_len_nxt = '0;
                  state_nxt    = S_CAPTURE;
               end else begin
                  ov_nxt     = 1'b1;
                  od_nxt     = mem_q;
                  rd_ptr_nxt = rd_ptr + 1'b1;
               end
            end
         end
         default: state_nxt = S_GHDR;
      endcase
   end

   assign ready     = (state == S_CAPTURE);
   assign outvalid  = ov;
   assign outdata   = od;
   assign pktcount  = pkt_cnt;
   assign truncated = trunc;

endmodule
